// File: rtl/rm_pkg.sv
// rm_pkg: definitions shared across the simple RISC datapath.
//   REG_W / NREG : default register width and register count
//   reg_idx_t    : register index (3 bits)
//   shift_op_t   : shifter operation code, same encoding as the shifter
//   of_state_t   : operand_fetch FSM states
package rm_pkg;

  localparam int REG_W = 16;
  localparam int NREG  = 8;

  typedef logic [2:0] reg_idx_t;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    LSL  = 2'b01,
    LSR  = 2'b10,
    ASR  = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_A,
    RD_B,
    VALID
  } of_state_t;

endpackage

// File: rtl/operand_fetch_regfile.sv
// regfile: NREG x DW general register array.
//   clk, reset : clock and synchronous active-high clear of every register
//   wr_en      : write enable; wr_idx / wr_data give the target and the value
//   rd_idx     : combinational read address
//   rd_data    : read data, write-first (a same-cycle write to rd_idx is
//                forwarded instead of the stale array contents)
module regfile #(
  parameter  int DW   = 16,
  parameter  int NREG = 8,
  localparam int IW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [DW-1:0] wr_data,
  input  logic [IW-1:0] rd_idx,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [NREG];

  // NOTE: this array is cleared by reset, so it maps to flops, not a RAM
  // macro; a reset loop over a real memory would not be synthesizable.
  // Reset also wins over a write in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Bypass keeps a writeback landing in the read cycle from being missed.
  assign rd_data = (wr_en && (wr_idx == rd_idx)) ? wr_data : mem[rd_idx];

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: reads Rn and Rm from the register file one per cycle,
// latches them into the A/B operand registers and offers them, together
// with the captured shift code, under a valid/ready handshake.
//   clk, reset          : clock, synchronous active-high reset
//   start               : fetch request, sampled only in IDLE
//   rn, rm, shift_in,
//   use_a               : request fields, captured on start
//   wb_en/wb_reg/wb_data: writeback port, live in every state
//   op_ready            : downstream accepts the operands
//   busy                : not in IDLE
//   op_valid            : a_out / b_out / shift_out are valid
//   a_out, b_out        : ALU operand and shifter data
//   shift_out           : shifter operation code
module operand_fetch
  import rm_pkg::*;
#(
  parameter  int DW   = rm_pkg::REG_W,
  parameter  int NREG = rm_pkg::NREG,
  localparam int IW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [IW-1:0] rn,
  input  logic [IW-1:0] rm,
  input  logic [1:0]    shift_in,
  input  logic          use_a,
  input  logic          wb_en,
  input  logic [IW-1:0] wb_reg,
  input  logic [DW-1:0] wb_data,
  input  logic          op_ready,
  output logic          busy,
  output logic          op_valid,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out,
  output logic [1:0]    shift_out
);

  of_state_t     state, state_nxt;
  logic [IW-1:0] rn_q, rm_q;
  shift_op_t     shift_q, shift_r;
  logic          use_a_q;
  logic [IW-1:0] rd_idx;
  logic [DW-1:0] rd_data;

  regfile #(.DW(DW), .NREG(NREG)) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wb_en),
    .wr_idx (wb_reg),
    .wr_data(wb_data),
    .rd_idx (rd_idx),
    .rd_data(rd_data)
  );

  // Single read port: Rn in RD_A, Rm otherwise.
  assign rd_idx = (state == RD_A) ? rn_q : rm_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: the default assignment first keeps this block free of latches
  // on any path that does not assign state_nxt.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = use_a ? RD_A : RD_B;
      RD_A:  state_nxt = RD_B;
      RD_B:  state_nxt = VALID;
      VALID: if (op_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pure decodes of the state register: no combinational input path.
  always_comb begin
    busy     = (state != IDLE);
    op_valid = (state == VALID);
  end

  // Request capture; only IDLE listens to start.
  always_ff @(posedge clk) begin
    if (reset) begin
      rn_q    <= '0;
      rm_q    <= '0;
      shift_q <= NONE;
      use_a_q <= 1'b0;
    end else if (state == IDLE && start) begin
      rn_q    <= rn;
      rm_q    <= rm;
      shift_q <= shift_op_t'(shift_in);
      use_a_q <= use_a;
    end
  end

  // Operand registers load only in RD_A / RD_B, so they stay frozen in VALID.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_out   <= '0;
      b_out   <= '0;
      shift_r <= NONE;
    end else begin
      case (state)
        RD_A: a_out <= rd_data;
        RD_B: begin
          b_out   <= rd_data;
          shift_r <= shift_q;
          if (!use_a_q) a_out <= '0;
        end
        default: ;
      endcase
    end
  end

  assign shift_out = shift_r;

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset, start, use_a, wb_en, op_ready;
  logic [2:0]  rn, rm, wb_reg;
  logic [1:0]  shift_in;
  logic [15:0] wb_data;
  logic        busy, op_valid;
  logic [15:0] a_out, b_out;
  logic [1:0]  shift_out;

  int n_checks = 0;
  int n_errors = 0;

  operand_fetch dut (
    .clk(clk), .reset(reset), .start(start), .rn(rn), .rm(rm),
    .shift_in(shift_in), .use_a(use_a), .wb_en(wb_en), .wb_reg(wb_reg),
    .wb_data(wb_data), .op_ready(op_ready), .busy(busy), .op_valid(op_valid),
    .a_out(a_out), .b_out(b_out), .shift_out(shift_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        use_a;
    logic [2:0]  rn;
    logic [2:0]  rm;
    logic [1:0]  sh;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [2:0] idx, input logic [15:0] data);
    wb_en = 1'b1; wb_reg = idx; wb_data = data;
    step();
    wb_en = 1'b0;
  endtask

  task automatic issue(input logic ua, input logic [2:0] a_idx, input logic [2:0] b_idx,
                       input logic [1:0] sh);
    start = 1'b1; use_a = ua; rn = a_idx; rm = b_idx; shift_in = sh;
    step();
    start = 1'b0;
  endtask

  // Counts edges from the start edge (inclusive) until op_valid; bounded.
  task automatic wait_valid(output int n);
    n = 1;
    while (!op_valid && n < 12) begin
      step();
      n++;
    end
  endtask

  task automatic fetch(input string name, input vec_t v);
    int n;
    op_ready = 1'b1;
    issue(v.use_a, v.rn, v.rm, v.sh);
    wait_valid(n);
    check({name, " latency"}, n, v.use_a ? 3 : 2);
    check({name, " a"}, a_out, v.exp_a);
    check({name, " b"}, b_out, v.exp_b);
    check({name, " shift"}, shift_out, v.sh);
    step();
    check({name, " idle after"}, busy, 1'b0);
  endtask

  vec_t vecs[6];

  initial begin
    int n;
    reset = 1'b1; start = 0; use_a = 0; wb_en = 0; op_ready = 0;
    rn = 0; rm = 0; wb_reg = 0; shift_in = 0; wb_data = 0;

    vecs[0] = '{1'b1, 3'd3, 3'd5, 2'b11, 16'h00F0, 16'h8001};
    vecs[1] = '{1'b0, 3'd3, 3'd5, 2'b00, 16'h0000, 16'h8001};
    vecs[2] = '{1'b1, 3'd5, 3'd5, 2'b01, 16'h8001, 16'h8001};
    vecs[3] = '{1'b1, 3'd7, 3'd1, 2'b10, 16'hFFFF, 16'h7FFF};
    vecs[4] = '{1'b1, 3'd0, 3'd7, 2'b00, 16'h0000, 16'hFFFF};
    vecs[5] = '{1'b0, 3'd7, 3'd3, 2'b10, 16'h0000, 16'h00F0};

    step(); step();
    reset = 1'b0;
    check("reset busy", busy, 1'b0);
    check("reset op_valid", op_valid, 1'b0);
    check("reset a", a_out, 16'h0);
    check("reset b", b_out, 16'h0);
    check("reset shift", shift_out, 2'b00);

    write_reg(3'd3, 16'h00F0);
    write_reg(3'd5, 16'h8001);
    write_reg(3'd1, 16'h7FFF);
    write_reg(3'd7, 16'hFFFF);

    for (int i = 0; i < 6; i++) fetch($sformatf("vec%0d", i), vecs[i]);

    // Stall in VALID while R5 is rewritten: latched operands must not move.
    op_ready = 1'b0;
    issue(1'b1, 3'd3, 3'd5, 2'b11);
    wait_valid(n);
    check("stall latency", n, 3);
    for (int i = 0; i < 5; i++) begin
      wb_en = (i == 0); wb_reg = 3'd5; wb_data = 16'h1234;
      step();
      wb_en = 1'b0;
      check($sformatf("stall%0d valid", i), op_valid, 1'b1);
      check($sformatf("stall%0d a", i), a_out, 16'h00F0);
      check($sformatf("stall%0d b", i), b_out, 16'h8001);
    end
    op_ready = 1'b1;
    step();
    check("stall release idle", busy, 1'b0);
    fetch("after stall R5", '{1'b0, 3'd0, 3'd5, 2'b01, 16'h0000, 16'h1234});

    // Bypass: write R5 during the RD_B cycle.
    op_ready = 1'b0;
    issue(1'b1, 3'd3, 3'd5, 2'b10);   // now in RD_A
    step();                           // now in RD_B
    wb_en = 1'b1; wb_reg = 3'd5; wb_data = 16'hBEEF;
    step();
    wb_en = 1'b0;
    check("bypass valid", op_valid, 1'b1);
    check("bypass b", b_out, 16'hBEEF);
    check("bypass a", a_out, 16'h00F0);
    op_ready = 1'b1;
    step();
    fetch("bypass persisted", '{1'b0, 3'd0, 3'd5, 2'b00, 16'h0000, 16'hBEEF});

    // start held during RD_A and VALID must be ignored.
    op_ready = 1'b0;
    issue(1'b1, 3'd3, 3'd5, 2'b01);   // now in RD_A
    start = 1'b1; rn = 3'd7; rm = 3'd1; use_a = 1'b0; shift_in = 2'b10;
    step(); step();                   // RD_B, then VALID
    check("ign valid", op_valid, 1'b1);
    check("ign a", a_out, 16'h00F0);
    check("ign b", b_out, 16'hBEEF);
    check("ign shift", shift_out, 2'b01);
    step();
    check("ign busy in valid", busy, 1'b1);
    check("ign still valid", op_valid, 1'b1);
    op_ready = 1'b1;
    step();                           // handoff edge with start=1: dropped
    start = 1'b0;
    check("ign handoff idle", busy, 1'b0);
    step();
    check("ign no restart busy", busy, 1'b0);
    check("ign no restart valid", op_valid, 1'b0);

    // Reset in RD_B, with a same-cycle write that must be discarded.
    issue(1'b1, 3'd3, 3'd5, 2'b11);   // RD_A
    step();                           // RD_B
    reset = 1'b1; wb_en = 1'b1; wb_reg = 3'd3; wb_data = 16'hAAAA;
    step();
    reset = 1'b0; wb_en = 1'b0;
    check("rst mid valid", op_valid, 1'b0);
    check("rst mid busy", busy, 1'b0);
    check("rst mid a", a_out, 16'h0);
    check("rst mid b", b_out, 16'h0);
    fetch("rst cleared R3", '{1'b1, 3'd3, 3'd3, 2'b00, 16'h0000, 16'h0000});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Upstream operand stage of the simple RISC datapath. Owns the 8×16 register file and reads the two source operands, Rn and Rm, through the file's single read port, one per cycle. It latches them into the A and B operand registers and presents B (with the captured shift code) to the shifter and A to the ALU under a valid/ready handshake. Writeback from the end of the datapath enters through a write port that is always live.

## Interface
Parameters:
- `DW`, default 16: data width of registers and operands.
- `NREG`, default 8: number of general registers; register index width is log2(NREG) = 3.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: reset is synchronous and active-high.
- `start`, input, 1: fetch request; sampled only in IDLE.
- `rn`, input, 3: index of the A source register; captured on start.
- `rm`, input, 3: index of the B source register; captured on start.
- `shift_in`, input, 2: shift code; captured on start.
- `use_a`, input, 1: 1 means read Rn; 0 means skip the Rn read and force A to 0 (MOV-type operations). Captured on start.
- `wb_en`, input, 1: register-file write enable.
- `wb_reg`, input, 3: write index.
- `wb_data`, input, DW: write data.
- `op_ready`, input, 1: downstream accepts the operands.
- `busy`, output, 1: 1 in every state except IDLE.
- `op_valid`, output, 1: A, B and shift outputs are valid.
- `a_out`, output, DW: A operand, routed to the ALU.
- `b_out`, output, DW: B operand, routed to the shifter data input.
- `shift_out`, output, 2: routed to the shifter op input.

## Operation
- The FSM has four states: IDLE, RD_A, RD_B, VALID.
- IDLE:
  - If start=1, capture `rn`, `rm`, `shift_in` and `use_a`.
  - Go to RD_A if use_a=1; otherwise go to RD_B.
  - If start=0, stay in IDLE.
- RD_A: the read port addresses the captured Rn. At the clock edge, `a_out` is loaded from the read data, then the FSM goes to RD_B.
- RD_B:
  - The read port addresses the captured Rm. At the clock edge, `b_out` is loaded from the read data and `shift_out` is loaded from the captured code.
  - If use_a=0, `a_out` is loaded with 0 on the same edge.
  - The FSM then goes to VALID.
- VALID:
  - `op_valid`=1, and `a_out`, `b_out`, `shift_out` hold steady.
  - If op_ready=1, go to IDLE. Otherwise stay in VALID, with outputs stable indefinitely.
- `start` is ignored in every state except IDLE. A start raised in the same cycle as the VALID-to-IDLE handoff is dropped; the requester must hold or re-raise it.
- Register-file writes:
  - A write with wb_en=1 updates `reg[wb_reg]` at the clock edge, in any FSM state.
  - The read port is write-first: if wb_en=1 and wb_reg equals the address being read in that cycle, the read returns `wb_data`, not the stale value.
- Writes during VALID never alter the already-latched `a_out` or `b_out`.
- Rn and Rm may be equal; the register is simply read twice.

## Timing
- Reset, taking effect at the edge where reset=1:
  - FSM goes to IDLE.
  - All NREG registers clear to 0.
  - `a_out`=0, `b_out`=0, `shift_out`=2'b00, `op_valid`=0, `busy`=0.
- Reset mid-fetch:
  - Abandons the request with no partial output.
  - Any wb_en asserted in the same cycle is discarded.
- Latency, with start sampled at edge 0:
  - use_a=1: RD_A during cycle 1, RD_B during cycle 2, `op_valid`=1 from cycle 3 onward.
  - use_a=0: RD_B during cycle 1, `op_valid`=1 from cycle 2 onward.
- Throughput: the minimum request period is 4 cycles (use_a=1) or 3 cycles (use_a=0), counting the IDLE cycle.
- `op_valid` and `busy` are registered state decodes, with no combinational path from any input.
- The read data path is combinational from the register array plus the bypass mux. It must meet single-cycle timing into the A/B registers.

## Structure
- Shared package `rm_pkg` holds:
  - `REG_W`=16 and `NREG`=8.
  - typedef `reg_idx_t` (3 bits).
  - typedef `shift_op_t` (2 bits): NONE=00, LSL=01, LSR=10, ASR=11. This must agree with the shifter's encoding.
  - enum `of_state_t`: IDLE, RD_A, RD_B, VALID.
- Sub-module `regfile`: NREG×DW array with one write port, one combinational read port, write-first bypass, and synchronous clear on reset.
- `operand_fetch` itself contains the FSM, the capture registers and the A/B/shift output registers.

## Test plan
- After reset, write R3=16'h00F0 and R5=16'h8001. Then start with rn=3, rm=5, shift=11, use_a=1, op_ready=1. Required: `op_valid` rises exactly 3 cycles after start, with a=16'h00F0, b=16'h8001, shift=11. FSM returns to IDLE the next cycle.
- use_a=0, rm=5: `op_valid` is asserted 2 cycles after start, with a=16'h0000 and b=16'h8001.
- op_ready held low for 5 cycles in VALID while writing R5=16'h1234. Required: outputs stay a=16'h00F0, b=16'h8001 throughout. After op_ready=1, the FSM is in IDLE the next cycle.
- Bypass: in the RD_B cycle, wb_en=1, wb_reg=rm=5, wb_data=16'hBEEF. Required: b=16'hBEEF, and R5 reads 16'hBEEF on later fetches.
- Start pulsed during RD_A and during VALID is ignored: only one `op_valid` episode, and busy stays 1 until handoff.
- Reset asserted in RD_B: next cycle `op_valid`=0, a=b=0, busy=0. A later fetch of R3 returns 16'h0000.
